// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store initiator.
package mips_lsu_pkg;

  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LBU = 3'd1,
    LSU_LH  = 3'd2,
    LSU_LHU = 3'd3,
    LSU_LW  = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic logic is_store(input lsu_op_t op);
    return op inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    return !is_store(op);
  endfunction

  function automatic logic is_byte(input lsu_op_t op);
    return op inside {LSU_LB, LSU_LBU, LSU_SB};
  endfunction

  function automatic logic is_half(input lsu_op_t op);
    return op inside {LSU_LH, LSU_LHU, LSU_SH};
  endfunction

  // Halfwords drop addr[0], words drop addr[1:0].
  function automatic logic [1:0] eff_off(input lsu_op_t op,
                                         input logic [1:0] o);
    if (is_byte(op)) return o;
    if (is_half(op)) return {o[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic logic misaligned(input lsu_op_t op,
                                      input logic [1:0] o);
    if (is_byte(op)) return 1'b0;
    if (is_half(op)) return o[0];
    return o != 2'b00;
  endfunction

endpackage

// File: rtl/mips_load_store_initiator_if.sv
// Request/response and data-memory bus bundle for the load/store initiator.
interface mips_load_store_initiator_if;
  import mips_lsu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  lsu_op_t               req_op;
  logic [LSU_ADDR_W-1:0] req_addr;
  logic [LSU_DATA_W-1:0] req_wdata;
  logic                  resp_valid;
  logic [LSU_DATA_W-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_active;
  logic [LSU_ADDR_W-1:0] mem_address;
  logic                  mem_wr_en;
  logic                  mem_read_en;
  logic [3:0]            mem_byte_en;
  logic [LSU_DATA_W-1:0] mem_data_in;
  logic [LSU_DATA_W-1:0] mem_data_out;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_active, mem_address, mem_wr_en, mem_read_en,
    output mem_byte_en, mem_data_in
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_active, mem_address, mem_wr_en, mem_read_en,
    input  mem_byte_en, mem_data_in
  );

endinterface

// File: rtl/mips_lsu_lane_align.sv
// Store lane packing / byte enables and load byte extraction / extension.
module mips_lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  lsu_op_t     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_raw,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_data_in,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Read data is big-endian across the word: byte o sits at [31-8o -: 8].
  assign w_sh   = {i_off, 3'b000};
  assign w_byte = i_rdata_raw[5'd31 - w_sh -: 8];
  assign w_half = {w_byte, i_rdata_raw[5'd23 - w_sh -: 8]};

  always_comb begin
    o_byte_en = 4'h0;
    o_data_in = '0;
    o_rdata   = '0;
    unique case (i_op)
      LSU_LB: begin
        o_byte_en = 4'b0001 << i_off;
        o_rdata   = {{24{w_byte[7]}}, w_byte};
      end
      LSU_LBU: begin
        o_byte_en = 4'b0001 << i_off;
        o_rdata   = {24'h0, w_byte};
      end
      LSU_LH: begin
        o_byte_en = 4'b0011 << i_off;
        o_rdata   = {{16{w_half[15]}}, w_half};
      end
      LSU_LHU: begin
        o_byte_en = 4'b0011 << i_off;
        o_rdata   = {16'h0, w_half};
      end
      LSU_LW: begin
        o_byte_en = 4'hF;
        o_rdata   = i_rdata_raw;
      end
      LSU_SB: begin
        o_byte_en = 4'b0001 << i_off;
        o_data_in = {24'h0, i_wdata[7:0]} << w_sh;
      end
      LSU_SH: begin
        o_byte_en = 4'b0011 << i_off;
        o_data_in = {16'h0, i_wdata[7:0], i_wdata[15:8]} << w_sh;
      end
      LSU_SW: begin
        o_byte_en = 4'hF;
        o_data_in = {i_wdata[7:0], i_wdata[15:8],
                     i_wdata[23:16], i_wdata[31:24]};
      end
    endcase
  end

endmodule

// File: rtl/mips_load_store_initiator.sv
// CPU-side load/store initiator for the byte-addressed MIPS data memory.
// Optional MIPS_LSU_ADDR_ERR_EN: misaligned half/word accesses report resp_err.
module mips_load_store_initiator
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        halt,
  mips_load_store_initiator_if.master bus
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  lsu_op_t           r_op;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [DATA_W-1:0] r_rdata;
  logic [3:0]        r_be;
  logic              r_wr;
  logic              r_rd;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic              r_active;
  logic              r_halt_seen;

  logic              w_idle;
  logic              w_accept;
  logic              w_err;
  lsu_op_t           w_op;
  logic [1:0]        w_off_in;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_din;
  logic [DATA_W-1:0] w_rdata;

  assign w_idle        = r_state == IDLE;
  assign bus.req_ready = w_idle & r_active & ~halt & ~r_halt_seen;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_off_in      = eff_off(bus.req_op, bus.req_addr[1:0]);

`ifdef MIPS_LSU_ADDR_ERR_EN
  assign w_err = misaligned(bus.req_op, bus.req_addr[1:0]);
`else
  assign w_err = 1'b0;
`endif

  // Packing uses the live request in IDLE, extraction the held one later.
  assign w_op  = w_idle ? bus.req_op : r_op;
  assign w_off = w_idle ? w_off_in : r_off;

  mips_lsu_lane_align u_align (
    .i_op       (w_op),
    .i_off      (w_off),
    .i_wdata    (bus.req_wdata),
    .i_rdata_raw(bus.mem_data_out),
    .o_byte_en  (w_be),
    .o_data_in  (w_din),
    .o_rdata    (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = w_err ? RESP : ACCESS;
      ACCESS: w_next = is_store(r_op) ? RESP : WAIT;
      WAIT:   w_next = RESP;
      RESP:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op         <= LSU_LB;
      r_off        <= 2'b00;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_rdata      <= '0;
      r_be         <= 4'h0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_rdata      <= '0;
      r_be         <= 4'h0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_idle && w_accept) begin
        r_op  <= bus.req_op;
        r_off <= w_off_in;
        if (w_err) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end else begin
          r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          r_be       <= w_be;
          r_mem_din  <= w_din;
          r_wr       <= is_store(bus.req_op);
          r_rd       <= is_load(bus.req_op);
        end
      end
      if (r_state == ACCESS && is_store(r_op)) r_resp_valid <= 1'b1;
      if (r_state == WAIT) begin
        r_resp_valid <= 1'b1;
        r_rdata      <= w_rdata;
      end
    end
  end

  // mem_active may only drop between accesses; halt is remembered until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_halt_seen <= 1'b0;
    end else begin
      r_halt_seen <= r_halt_seen | halt;
      if (w_idle && (halt || r_halt_seen)) r_active <= 1'b0;
      else if (!halt && !r_halt_seen)      r_active <= 1'b1;
    end
  end

  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_rdata;
  assign bus.resp_err    = r_resp_err;
  assign bus.mem_active  = r_active;
  assign bus.mem_address = r_mem_addr;
  assign bus.mem_wr_en   = r_wr;
  assign bus.mem_read_en = r_rd;
  assign bus.mem_byte_en = r_be;
  assign bus.mem_data_in = r_mem_din;

endmodule

// File: tb/tb_mips_load_store_initiator.sv
// Scoreboard bench for mips_load_store_initiator against a byte-array model.
module tb_mips_load_store_initiator;
  import mips_lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] din;
    int          cyc;
  } mem_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt = 1'b0;
  logic load_img = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  resp_t q_resp[$];
  mem_t  q_mem[$];
  logic [7:0] img[256];
  logic [7:0] ref_mem[256];
  logic [7:0] dev_mem[256];
  mem_t  mm;
  resp_t rr;

  mips_load_store_initiator_if bus();

  mips_load_store_initiator #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .halt (halt),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: byte address+k on lane k for writes, big-endian read word.
  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= img[i];
    end else begin
      if (bus.mem_wr_en)
        for (int k = 0; k < 4; k++)
          if (bus.mem_byte_en[k])
            dev_mem[bus.mem_address[7:0] | 8'(k)] <= bus.mem_data_in[8*k +: 8];
      if (bus.mem_read_en)
        bus.mem_data_out <= {dev_mem[{bus.mem_address[7:2], 2'd0}],
                             dev_mem[{bus.mem_address[7:2], 2'd1}],
                             dev_mem[{bus.mem_address[7:2], 2'd2}],
                             dev_mem[{bus.mem_address[7:2], 2'd3}]};
    end
  end

  always @(negedge clk) begin
    if (!reset && !load_img) begin
      if (bus.mem_read_en || bus.mem_wr_en) begin
        checks++;
        if (q_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_strobe unexpected cyc=%0d rd=%b wr=%b addr=%h",
                   cyc, bus.mem_read_en, bus.mem_wr_en, bus.mem_address);
        end else begin
          mm = q_mem.pop_front();
          if (bus.mem_address !== mm.addr || bus.mem_wr_en !== mm.wr ||
              bus.mem_read_en !== !mm.wr || bus.mem_byte_en !== mm.be ||
              bus.mem_data_in !== mm.din || cyc != mm.cyc) begin
            errors++;
            $display("FAIL mem_bus got addr=%h wr=%b rd=%b be=%b din=%h cyc=%0d exp addr=%h wr=%b be=%b din=%h cyc=%0d",
                     bus.mem_address, bus.mem_wr_en, bus.mem_read_en,
                     bus.mem_byte_en, bus.mem_data_in, cyc,
                     mm.addr, mm.wr, mm.be, mm.din, mm.cyc);
          end
        end
      end
      if (bus.resp_valid) begin
        checks++;
        if (q_resp.size() == 0) begin
          errors++;
          $display("FAIL resp unexpected cyc=%0d rdata=%h err=%b",
                   cyc, bus.resp_rdata, bus.resp_err);
        end else begin
          rr = q_resp.pop_front();
          if (bus.resp_rdata !== rr.rdata || bus.resp_err !== rr.err ||
              cyc != rr.cyc) begin
            errors++;
            $display("FAIL resp got rdata=%h err=%b cyc=%0d exp rdata=%h err=%b cyc=%0d",
                     bus.resp_rdata, bus.resp_err, cyc,
                     rr.rdata, rr.err, rr.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int op_size(input lsu_op_t op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  task automatic issue(input lsu_op_t op, input logic [31:0] a,
                       input logic [31:0] wd);
    int          n;
    int          to;
    int          k;
    logic        st;
    logic        err;
    logic [31:0] ea;
    logic [31:0] v;
    logic [31:0] rd;
    mem_t        m;
    to = 0;
    @(negedge clk);
    while (!bus.req_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout got=0 exp=1");
      return;
    end
    n  = op_size(op);
    st = op inside {LSU_SB, LSU_SH, LSU_SW};
    ea = a & ~32'(n - 1);
`ifdef MIPS_LSU_ADDR_ERR_EN
    err = ea != a;
`else
    err = 1'b0;
`endif
    if (err) begin
      q_resp.push_back('{32'h0, 1'b1, cyc + 1});
    end else begin
      m.addr = {ea[31:2], 2'b00};
      m.wr   = st;
      m.be   = 4'h0;
      m.din  = 32'h0;
      m.cyc  = cyc + 1;
      for (int i = 0; i < n; i++) begin
        k = int'(ea[1:0]) + i;
        m.be[k] = 1'b1;
        if (st) m.din[8*k +: 8] = wd[8*(n-1-i) +: 8];
      end
      q_mem.push_back(m);
      if (st) begin
        for (int i = 0; i < n; i++)
          ref_mem[8'(ea[7:0] + 8'(i))] = wd[8*(n-1-i) +: 8];
        q_resp.push_back('{32'h0, 1'b0, cyc + 2});
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++)
          v = {v[23:0], ref_mem[8'(ea[7:0] + 8'(i))]};
        case (op)
          LSU_LB:  rd = {{24{v[7]}}, v[7:0]};
          LSU_LBU: rd = {24'h0, v[7:0]};
          LSU_LH:  rd = {{16{v[15]}}, v[15:0]};
          LSU_LHU: rd = {16'h0, v[15:0]};
          default: rd = v;
        endcase
        q_resp.push_back('{rd, 1'b0, cyc + 3});
      end
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = lsu_op_t'($urandom_range(0, 7));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    halt  = 1'b0;
    q_resp.delete();
    q_mem.delete();
    #1;
    check("reset_ctl", {24'h0, bus.req_ready, bus.resp_valid, bus.resp_err,
                        bus.mem_active, bus.mem_wr_en, bus.mem_read_en,
                        2'b00}, 32'h0);
    check("reset_be", {28'h0, bus.mem_byte_en}, 32'h0);
    check("reset_addr", bus.mem_address, 32'h0);
    check("reset_din", bus.mem_data_in, 32'h0);
    check("reset_rdata", bus.resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    load_img = 1'b0;
    #1;
    check("active_before_clk", {31'h0, bus.mem_active}, 32'h0);
    @(posedge clk);
    #1;
    check("active_after_clk", {31'h0, bus.mem_active}, 32'h1);
  endtask

  initial begin
    int to;
    logic [31:0] ra;
    for (int i = 0; i < 256; i++) begin
      img[i]     = 8'($urandom);
      ref_mem[i] = img[i];
    end
    bus.req_valid = 1'b0;
    bus.req_op    = LSU_LB;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    #1;
    do_reset();

    issue(LSU_SW,  32'h10, 32'h11223344);
    issue(LSU_LW,  32'h10, 32'h0);
    issue(LSU_SB,  32'h21, 32'h000000AB);
    issue(LSU_LB,  32'h21, 32'h0);
    issue(LSU_LBU, 32'h21, 32'h0);
    issue(LSU_SH,  32'h32, 32'h00008001);
    issue(LSU_LH,  32'h32, 32'h0);
    issue(LSU_LHU, 32'h32, 32'h0);

    for (int t = 0; t < 300; t++) begin
      ra = $urandom;
      if (t % 3 == 0) ra[31:8] = 24'h0;
      issue(lsu_op_t'($urandom_range(0, 7)), ra, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    to = 0;
    while ((q_resp.size() != 0 || q_mem.size() != 0) && to < 20) begin
      @(negedge clk);
      to++;
    end
    issue(LSU_LW, 32'h44, 32'h0);
    @(posedge clk);
    #1;
    do_reset();
    issue(LSU_LW, 32'h10, 32'h0);
    issue(LSU_LW, 32'h13, 32'h0);

    issue(LSU_SW, 32'h80, 32'hCAFEF00D);
    halt = 1'b1;
    @(negedge clk);
    check("active_during_store", {31'h0, bus.mem_active}, 32'h1);
    repeat (4) @(negedge clk);
    check("active_after_halt", {31'h0, bus.mem_active}, 32'h0);
    check("ready_after_halt", {31'h0, bus.req_ready}, 32'h0);
    halt = 1'b0;
    repeat (5) @(negedge clk);
    check("ready_stays_low", {31'h0, bus.req_ready}, 32'h0);
    check("active_stays_low", {31'h0, bus.mem_active}, 32'h0);

    to = 0;
    while ((q_resp.size() != 0 || q_mem.size() != 0) && to < 20) begin
      @(negedge clk);
      to++;
    end
    check("queues_empty", 32'(q_resp.size() + q_mem.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
